// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider that produces one quotient bit per clock, with a start/busy/done handshake.
// Defining DIVIDER_SIGNED_EN enables two's-complement operands and a FIX state that restores the result signs.
module subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_minuend,
  input  logic [W-1:0] i_subtrahend,
  output logic [W-1:0] o_difference,
  output logic         o_borrow
);
  assign {o_borrow, o_difference} = {1'b0, i_minuend} - {1'b0, i_subtrahend};
endmodule

module restoring_divider #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero
);
  localparam int CW = $clog2(N + 1);

`ifdef DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t        r_state, w_next;
  logic [N-1:0]  r_rem, r_q, r_div;
  logic [CW-1:0] r_cnt;
  logic          r_dz;
  logic [N:0]    w_t, w_diff;
  logic          w_borrow, w_take, w_last, w_accept;
  logic [N-1:0]  w_rem_nxt, w_q_nxt, w_dd_ld, w_dv_ld;
`ifdef DIVIDER_SIGNED_EN
  logic          r_neg_q, r_neg_r;
`endif

  assign o_busy   = (r_state != S_IDLE);
  assign w_accept = i_start & ~o_busy;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_t      = {r_rem, r_q[N-1]};

  subtractor #(.W(N + 1)) u_sub (
    .i_minuend   (w_t),
    .i_subtrahend({1'b0, r_div}),
    .o_difference(w_diff),
    .o_borrow    (w_borrow)
  );

  // Without a borrow the difference is below the divisor, so bit N is always clear.
  assign w_take    = ~w_borrow & ~w_diff[N];
  assign w_rem_nxt = w_take ? w_diff[N-1:0] : w_t[N-1:0];
  assign w_q_nxt   = {r_q[N-2:0], w_take};

`ifdef DIVIDER_SIGNED_EN
  // A zero divisor keeps the raw dividend because it is returned as the remainder.
  assign w_dd_ld = (i_dividend[N-1] && (i_divisor != '0)) ? -i_dividend : i_dividend;
  assign w_dv_ld = i_divisor[N-1] ? -i_divisor : i_divisor;
`else
  assign w_dd_ld = i_dividend;
  assign w_dv_ld = i_divisor;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
`ifdef DIVIDER_SIGNED_EN
      S_RUN:  if (r_dz) w_next = S_IDLE;
              else if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
`else
      S_RUN:  if (r_dz || w_last) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rem         <= '0;
      r_q           <= '0;
      r_div         <= '0;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          o_quotient    <= '0;
          o_remainder   <= '0;
          o_div_by_zero <= 1'b0;
          r_rem         <= '0;
          r_cnt         <= '0;
          r_q           <= w_dd_ld;
          r_div         <= w_dv_ld;
          r_dz          <= (i_divisor == '0);
`ifdef DIVIDER_SIGNED_EN
          r_neg_q       <= i_dividend[N-1] ^ i_divisor[N-1];
          r_neg_r       <= i_dividend[N-1];
`endif
        end
        S_RUN: if (r_dz) begin
          o_quotient    <= '1;
          o_remainder   <= r_q;
          o_div_by_zero <= 1'b1;
          o_done        <= 1'b1;
        end else begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
`ifndef DIVIDER_SIGNED_EN
          if (w_last) begin
            o_quotient  <= w_q_nxt;
            o_remainder <= w_rem_nxt;
            o_done      <= 1'b1;
          end
`endif
        end
`ifdef DIVIDER_SIGNED_EN
        S_FIX: begin
          o_quotient  <= r_neg_q ? -r_q : r_q;
          o_remainder <= r_neg_r ? -r_rem : r_rem;
          o_done      <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
- Produces one quotient bit per clock.
- Instantiates the team's Subtractor at width N+1 as its only arithmetic element. It drives minuend and subtrahend and consumes difference and borrow each iteration.
- Sits behind the ALU issue logic as the long-latency DIV/MOD unit, using a start/busy/done handshake.

Parameters:
- N, 8, operand, quotient and remainder width in bits (N >= 2).

Ports:
- i_clock  input  1  system clock, rising-edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  request a division; sampled only while o_busy = 0.
- i_dividend  input  N  dividend, captured on the accepting edge.
- i_divisor  input  N  divisor, captured on the accepting edge.
- o_busy  output  1  high while a division is in progress.
- o_done  output  1  one-cycle pulse: results valid.
- o_quotient  output  N  quotient; held until the next accepted start.
- o_remainder  output  N  remainder; held until the next accepted start.
- o_div_by_zero  output  1  high with results when the captured divisor = 0; held with results.

Behaviour:
- Reset (i_reset_n = 0, asynchronous, any time including mid-division):
  - All outputs go to 0, the FSM goes to IDLE and the iteration counter clears.
  - An in-flight operation is discarded and no o_done is produced for it.
- States:
  - IDLE: wait for start.
  - RUN: N iterations.
  - FIX: signed fix-up; present only with the optional feature.
- Accept (edge 0): i_start = 1 while o_busy = 0 captures both operands.
  - Clears o_done, o_quotient, o_remainder and o_div_by_zero.
  - Partial remainder R (N+1 bits) = 0; shift register Q = dividend; counter = 0.
- Divide by zero on accept: skip RUN.
  - On edge 1: o_quotient = all ones, o_remainder = dividend, o_div_by_zero = 1, o_done = 1, o_busy = 0.
- Otherwise go to RUN; o_busy = 1 from edge 0.
- Each RUN edge:
  - T = {R[N-1:0], Q[N-1]}.
  - The Subtractor computes T - {1'b0, divisor}.
  - If borrow = 0: R = difference, shift 1 into Q[0]. If borrow = 1: R = T (restore), shift 0 into Q[0].
  - Q shifts left by one; counter increments.
- After iteration N (edge N):
  - o_quotient = Q, o_remainder = R[N-1:0], o_done = 1 for exactly one cycle, o_busy = 0, return to IDLE.
- Latency: o_done is high in the cycle after edge N (nonzero divisor) or after edge 1 (divisor = 0).
- Back-to-back: i_start is accepted in the same cycle o_done is high, because o_busy = 0 then. The new accept clears o_done on that edge.
- i_start while o_busy = 1 is ignored with no side effects. Operand inputs are don't-care except on the accepting edge.
- R never exceeds N significant bits after restore; the N+1-bit width exists only so T cannot overflow.
- Dividend = 0 gives quotient 0 and remainder 0 after the full N cycles (no early exit).

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken on accept and the RUN datapath is unchanged.
  - The extra FIX state (edge N+1) negates the quotient if operand signs differ. The remainder takes the dividend's sign.
  - o_done is high in the cycle after edge N+1, and o_busy covers edges 0..N+1.
  - -2^(N-1) / -1 returns quotient bits 2^(N-1) (wraps) and remainder 0, with no flag.
  - Divide-by-zero behaviour is unchanged (quotient all ones, remainder = raw dividend, no FIX).
- Undefined: purely unsigned; the FIX state and the negation logic are absent.

Test Plan:
- N=8, start 200 / 7 -> o_busy high 8 cycles; o_done one cycle after edge 8; quotient 28, remainder 4, o_div_by_zero 0.
- Start 5 / 0 -> o_done after edge 1; quotient 0xFF, remainder 5, o_div_by_zero 1; no RUN cycles.
- 255 / 1 then i_start held high through o_done with 100 / 10 -> first result 255 r0 (one o_done pulse); second accepted in the o_done cycle, giving 10 r0 eight cycles later.
- Start 100 / 3, pulse i_start again at edge 4 with 9 / 9 -> second request ignored; result 33 r1.
- Start 200 / 7, assert i_reset_n = 0 between edges 3 and 4 (asynchronously), release -> all outputs 0 immediately, no o_done; a fresh 15 / 4 then gives 3 r3.
- DIVIDER_SIGNED_EN: -7 / 2 -> quotient 0xFD, remainder 0xFF, o_done after edge 9.
- DIVIDER_SIGNED_EN: -128 / -1 -> quotient 0x80, remainder 0.
